// File: rtl/seq_cla_adder_32.sv
// rtl/seq_cla_adder_32.sv - multi-cycle 32-bit lookahead adder/subtractor
//
// Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock.
// Inside a slice, carries come from two levels of 4-bit lookahead. Between
// slices, the carry is held in a register (carry_r).
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        operation request, accepted whenever busy=0
//   a, b         operands, latched on an accepted start
//   cin          carry-in for add (ignored when sub=1)
//   sub          1: a - b (a + ~b + 1), 0: a + b + cin
//   busy         high while slices are being computed
//   done         one-cycle pulse when sum and flags are final
//   sum          result, held until the next accepted start
//   cout         carry out of the MSB
//   overflow     signed overflow (carry into MSB xor carry out)
//   zero         final sum is all zeros
module seq_cla_adder_32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int NG = CHUNK / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [KW-1:0]    k;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] c;
  logic [CHUNK-1:0] slice_sum;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_next;

  assign accept = start && (state != S_RUN);
  assign last   = (k == KW'(N - 1));
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Slice datapath. Every carry is written as a flat sum of products:
  // acc collects the generate terms and pre the running propagate product.
  // No carry ripples through another carry's logic.
  always_comb begin : slice_logic
    logic acc;
    logic pre;
    acc       = 1'b0;
    pre       = 1'b0;
    gp        = '0;
    gg        = '0;
    gc        = '0;
    c         = '0;
    sa        = a_r[k*CHUNK +: CHUNK];
    sb        = b_r[k*CHUNK +: CHUNK];
    p         = sa ^ sb;
    g         = sa & sb;

    // First level: group propagate/generate of each 4-bit group.
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      acc   = g[4*j+3];
      pre   = p[4*j+3];
      for (int m = 2; m >= 0; m--) begin
        acc = acc | (pre & g[4*j+m]);
        pre = pre & p[4*j+m];
      end
      gg[j] = acc;
    end

    // Second level: group carries from carry_r. gc[NG] is the slice carry-out.
    gc[0] = carry_r;
    for (int j = 0; j < NG; j++) begin
      acc = gg[j];
      pre = gp[j];
      for (int m = j - 1; m >= 0; m--) begin
        acc = acc | (pre & gg[m]);
        pre = pre & gp[m];
      end
      gc[j+1] = acc | (pre & carry_r);
    end

    // First level again: bit carries within each group from its group carry.
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int i = 0; i < 3; i++) begin
        acc = g[4*j+i];
        pre = p[4*j+i];
        for (int m = i - 1; m >= 0; m--) begin
          acc = acc | (pre & g[4*j+m]);
          pre = pre & p[4*j+m];
        end
        c[4*j+i+1] = acc | (pre & gc[j]);
      end
    end

    slice_sum                   = p ^ c;
    sum_next                    = sum;
    sum_next[k*CHUNK +: CHUNK]  = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      k        <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1, so the inversion and the +1 are applied
      // here and the slice logic only ever adds.
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub | cin;
      k       <= '0;
      sum     <= '0;
    end else if (state == S_RUN) begin
      sum     <= sum_next;
      carry_r <= gc[NG];
      if (last) begin
        k        <= '0;
        cout     <= gc[NG];
        overflow <= c[CHUNK-1] ^ gc[NG];
        zero     <= (sum_next == '0);
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_cla_adder_32.sv
// tb/tb_seq_cla_adder_32.sv - self-checking bench for seq_cla_adder_32
module tb_seq_cla_adder_32;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  seq_cla_adder_32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference arithmetic: returns {overflow, cout, sum}.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
    logic [31:0] yy;
    logic [32:0] r;
    logic        ov;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
    ov = (x[31] == yy[31]) && (r[31] != x[31]);
    return {ov, r[32], r[31:0]};
  endfunction

  // Behavioural model: tracks remaining run cycles and the expected result.
  int          m_run = 0;
  logic        m_done = 1'b0;
  logic        m_fresh = 1'b0;
  logic        m_valid = 1'b0;
  logic [33:0] p_res = '0;
  logic [31:0] e_sum = '0;
  logic        e_cout = 1'b0;
  logic        e_ovf = 1'b0;
  logic        e_zero = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_run   <= 0;
      m_done  <= 1'b0;
      m_fresh <= 1'b1;
      m_valid <= 1'b1;
      e_sum   <= '0;
      e_cout  <= 1'b0;
      e_ovf   <= 1'b0;
      e_zero  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (start && m_run == 0) begin
        p_res   <= ref_add(a, b, cin, sub);
        m_run   <= N;
        m_valid <= 1'b0;
        m_fresh <= 1'b0;
      end else if (m_run > 0) begin
        m_run <= m_run - 1;
        if (m_run == 1) begin
          m_done  <= 1'b1;
          m_valid <= 1'b1;
          e_sum   <= p_res[31:0];
          e_cout  <= p_res[32];
          e_ovf   <= p_res[33];
          e_zero  <= (p_res[31:0] == 32'd0);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cyc_busy", busy, (m_run > 0));
    chk("cyc_done", done, m_done);
    if (m_valid) chk("cyc_sum", sum, e_sum);
    if (m_done || m_fresh) begin
      chk("cyc_cout", cout, e_cout);
      chk("cyc_overflow", overflow, e_ovf);
      chk("cyc_zero", zero, e_zero);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                              input logic vs, input logic [31:0] es, input logic eco,
                              input logic eov, input logic ez);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.s = es; v.co = eco; v.ov = eov; v.z = ez;
    return v;
  endfunction

  vec_t vecs[9];

  // mode 0: plain operation; 1: extra starts pulsed mid-run (ignored);
  // 2: reset asserted in the second run cycle together with a start.
  task automatic run_op(input vec_t v, input bit now, input int mode);
    logic [33:0] r;
    int lat;
    int bcnt;
    r = ref_add(v.a, v.b, v.cin, v.sub);
    if (mode != 2) chk("model_pin", r, {v.ov, v.co, v.s});
    if (!now) @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    lat = 0;
    bcnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #3;
      if (cyc == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
      if (mode == 1 && (cyc == 1 || cyc == 2)) begin
        start = 1'b1;
        a = $urandom; b = $urandom;
      end
      if (mode == 1 && cyc == 3) start = 1'b0;
      if (mode == 2 && cyc == 1) begin rst = 1'b1; start = 1'b1; end
      if (mode == 2 && cyc == 2) begin rst = 1'b0; start = 1'b0; end
      if (busy) bcnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    if (mode == 2) begin
      chk("rst_no_done", lat, 0);
      chk("rst_busy_cycles", bcnt, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_zero", zero, 0);
    end else begin
      chk("latency", lat, 5);
      chk("busy_cycles", bcnt, 4);
      chk("lit_sum", sum, v.s);
      chk("lit_cout", cout, v.co);
      chk("lit_overflow", overflow, v.ov);
      chk("lit_zero", zero, v.z);
    end
  endtask

  initial begin
    vecs[0] = mk(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    vecs[2] = mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    vecs[4] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    vecs[5] = mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    vecs[6] = mk(32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    vecs[7] = mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    vecs[8] = mk(32'h00FF00FF, 32'h0001FF01, 1'b0, 1'b0, 32'h01010000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_zero", zero, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], 1'b0, 0);
      repeat (2) @(negedge clk);
    end

    run_op(vecs[0], 1'b0, 1);
    run_op(vecs[5], 1'b1, 0);
    repeat (2) @(negedge clk);

    run_op(vecs[4], 1'b0, 0);
    repeat (2) @(negedge clk);
    run_op(vecs[0], 1'b0, 2);
    run_op(vecs[2], 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
